// File: rtl/conv_pool_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv_pool_pkg : shared constants and types for the conv/pool sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv_pool_pkg;

  localparam int WIN   = 6;
  localparam int N_OUT = 18;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WINDOW  = 3'd2,
    WAIT    = 3'd3,
    EMIT    = 3'd4,
    ADVANCE = 3'd5,
    DONE    = 3'd6
  } state_e;

  typedef logic [WIN*WIN-1:0] win_t;

endpackage

`default_nettype wire

// File: rtl/conv_pool_sched_if.sv
// ---------------------------------------------------------------------------
// conv_pool_sched_if : control, memory, datapath and output bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface conv_pool_sched_if
  import conv_pool_pkg::*;
#(
  parameter int IMG_W  = 14,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [IMG_W-1:0]  mem_rd_data;
  win_t              win_image;
  logic [N_OUT-1:0]  dp_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_pixels;
  logic [ADDR_W-1:0] out_row;
  logic [ADDR_W-1:0] out_col;

  modport master (
    input  start, mem_rd_data, dp_pixel, out_ready,
    output busy, done, mem_rd_en, mem_rd_addr, win_image,
           out_valid, out_pixels, out_row, out_col
  );

  modport slave (
    output start, mem_rd_data, dp_pixel, out_ready,
    input  busy, done, mem_rd_en, mem_rd_addr, win_image,
           out_valid, out_pixels, out_row, out_col
  );
endinterface

`default_nettype wire

// File: rtl/conv_pool_sched_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer : WIN-row shift register with a WIN-wide column slice
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv_line_buffer
  import conv_pool_pkg::*;
#(
  parameter int IMG_W = 14,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_i,
  input  logic [IMG_W-1:0] row_i,
  input  logic [CW-1:0]    c0_i,
  output win_t             win_o
);

  // rows_q[0] is the oldest row, i.e. window row 0
  logic [IMG_W-1:0] rows_q [WIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) rows_q[i] <= '0;
    end else if (shift_i) begin
      for (int i = 0; i < WIN-1; i++) rows_q[i] <= rows_q[i+1];
      rows_q[WIN-1] <= row_i;
    end
  end

  for (genvar i = 0; i < WIN; i++) begin : g_row
    logic [IMG_W-1:0] shifted;
    assign shifted              = rows_q[i] >> c0_i;
    assign win_o[i*WIN +: WIN] = shifted[WIN-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/conv_pool_sched.sv
// ---------------------------------------------------------------------------
// conv_pool_sched : walks a stride-2 6x6 window over the map for the datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv_pool_sched
  import conv_pool_pkg::*;
#(
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int STRIDE = 2,
  parameter int DP_LAT = 1,
  parameter int ADDR_W = $clog2(IMG_H)
) (
  input  logic clk,
  input  logic rst_n,
  conv_pool_sched_if.master bus
);

  localparam int OUT_H = (IMG_H - WIN) / STRIDE + 1;
  localparam int OUT_W = (IMG_W - WIN) / STRIDE + 1;
  localparam int CW    = $clog2(IMG_W);
  localparam int RCW   = $clog2(WIN + 1);
  localparam int WCW   = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  localparam logic [RCW-1:0]    WIN_RD   = RCW'(WIN);
  localparam logic [RCW-1:0]    STR_RD   = RCW'(STRIDE);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] STR_A    = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] WIN_A    = ADDR_W'(WIN);
  localparam logic [CW-1:0]     STR_C    = CW'(STRIDE);
  localparam logic [WCW-1:0]    LAT_LAST = WCW'(DP_LAT - 1);

  if (((IMG_W - WIN) % STRIDE) != 0 || ((IMG_H - WIN) % STRIDE) != 0 || DP_LAT < 1)
  begin : g_bad_cfg
    $error("conv_pool_sched: map size incompatible with window/stride or DP_LAT < 1");
  end

  state_e            state_q;
  logic              busy_q, done_q, rd_en_q, rd_vld_q, valid_q;
  logic [ADDR_W-1:0] addr_q, r0_q, row_q, col_q, orow_q, ocol_q;
  logic [CW-1:0]     c0_q;
  logic [RCW-1:0]    rd_cnt_q;
  logic [WCW-1:0]    wait_q;
  logic [N_OUT-1:0]  pix_q;
  win_t              win_q;
  win_t              slice_d;

  conv_line_buffer #(.IMG_W(IMG_W), .CW(CW)) u_lbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_i (rd_vld_q),
    .row_i   (bus.mem_rd_data),
    .c0_i    (c0_q),
    .win_o   (slice_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      r0_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      orow_q   <= '0;
      ocol_q   <= '0;
      c0_q     <= '0;
      rd_cnt_q <= '0;
      wait_q   <= '0;
      pix_q    <= '0;
      win_q    <= '0;
    end else begin
      rd_vld_q <= rd_en_q;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= LOAD;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            addr_q   <= '0;
            rd_cnt_q <= RCW'(1);
            r0_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            c0_q     <= '0;
          end
        end
        LOAD, ADVANCE: begin
          // Reads go out back to back; the window starts once the last one lands
          if (rd_cnt_q < ((state_q == LOAD) ? WIN_RD : STR_RD)) begin
            rd_en_q  <= 1'b1;
            addr_q   <= addr_q + 1'b1;
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end else begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
          end
          if (rd_vld_q && !rd_en_q) begin
            state_q <= WINDOW;
            c0_q    <= '0;
            col_q   <= '0;
            if (state_q == ADVANCE) begin
              r0_q  <= r0_q + STR_A;
              row_q <= row_q + 1'b1;
            end
          end
        end
        WINDOW: begin
          win_q   <= slice_d;
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == LAT_LAST) begin
            pix_q   <= bus.dp_pixel;
            orow_q  <= row_q;
            ocol_q  <= col_q;
            valid_q <= 1'b1;
            state_q <= EMIT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (col_q != LAST_COL) begin
              col_q   <= col_q + 1'b1;
              c0_q    <= c0_q + STR_C;
              state_q <= WINDOW;
            end else if (row_q != LAST_ROW) begin
              state_q  <= ADVANCE;
              rd_en_q  <= 1'b1;
              addr_q   <= r0_q + WIN_A;
              rd_cnt_q <= RCW'(1);
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pix_q   <= '0;
              orow_q  <= '0;
              ocol_q  <= '0;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.win_image   = win_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_pixels  = pix_q;
  assign bus.out_row     = orow_q;
  assign bus.out_col     = ocol_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_pool_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_pool_sched : directed scoreboard bench for conv_pool_sched
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv_pool_sched;
  import conv_pool_pkg::*;

  localparam int W = 14, H = 14, AW = 4, SW = 6, SAW = 3, OH = 5, OW = 5;

  typedef struct packed {
    logic [AW-1:0]    r;
    logic [AW-1:0]    c;
    logic [N_OUT-1:0] p;
    win_t             w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_pool_sched_if #(.IMG_W(W),  .ADDR_W(AW))  bus ();
  conv_pool_sched_if #(.IMG_W(SW), .ADDR_W(SAW)) sbus ();

  conv_pool_sched #(.IMG_W(W), .IMG_H(H), .STRIDE(2), .DP_LAT(1), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  conv_pool_sched #(.IMG_W(SW), .IMG_H(SW), .STRIDE(2), .DP_LAT(1), .ADDR_W(SAW)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus));

  logic [W-1:0]  map  [H];
  logic [SW-1:0] smap [SW];

  always @(posedge clk) if (bus.mem_rd_en)  bus.mem_rd_data  <= map[bus.mem_rd_addr];
  always @(posedge clk) if (sbus.mem_rd_en) sbus.mem_rd_data <= smap[sbus.mem_rd_addr];
  always_comb bus.dp_pixel  = ($countones(bus.win_image)  >= 19) ? '1 : '0;
  always_comb sbus.dp_pixel = ($countones(sbus.win_image) >= 19) ? '1 : '0;

  int   n_pass = 0, n_tot = 0;
  int   cyc = 0, hs_cnt = 0, done_cnt = 0, last_hs = 0, stall_cnt = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic win_t ref_win(input int r0, input int c0);
    win_t w;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        w[i*WIN+j] = map[r0+i][c0+j];
    return w;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        map[r][c] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((r ^ c) & 1) : 1'($urandom_range(0, 1));
  endtask

  task automatic push_all();
    exp_t e;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        e.r = AW'(r);
        e.c = AW'(c);
        e.w = ref_win(2*r, 2*c);
        e.p = ($countones(e.w) >= 19) ? '1 : '0;
        sb.push_back(e);
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (bus.done) found = 1;
    end
    chk({tag, "_done_seen"}, 64'(found), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_outputs"}, 64'(hs_cnt), 64'd25);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic clear_counts();
    @(posedge clk); #1;
    hs_cnt = 0; done_cnt = 0; stall_cnt = 0;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: every handshake pops one expected output
  always @(negedge clk) begin
    exp_t e;
    int   hs;
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.mem_rd_en) chk("rd_addr_range", 64'(bus.mem_rd_addr < AW'(H)), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        hs = cyc + 1;
        hs_cnt++;
        n_tot++;
        assert (sb.size() > 0) begin
          n_pass++;
          e = sb.pop_front();
          chk("out_row", 64'(bus.out_row), 64'(e.r));
          chk("out_col", 64'(bus.out_col), 64'(e.c));
          chk("out_pixels", 64'(bus.out_pixels), 64'(e.p));
          chk("win_image", 64'(bus.win_image), 64'(e.w));
        end else $error("FAIL sb_underflow observed=%0d expected=none", hs_cnt);
        if (bus.out_col != '0 && stall_cnt == 0) chk("hs_gap", 64'(hs - last_hs), 64'd3);
        last_hs   = hs;
        stall_cnt = 0;
      end else if (!bus.out_ready) begin
        stall_cnt++;
      end
    end
  end

  initial begin
    logic [N_OUT-1:0] snap;
    win_t sw;
    int   found, t0;

    rst_n = 1'b0;
    bus.start = 1'b0;  bus.out_ready = 1'b1;
    sbus.start = 1'b0; sbus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_win", 64'(bus.win_image), 64'd0);
    chk("rst_pixels", 64'(bus.out_pixels), 64'd0);
    rst_n = 1'b1;

    // Run A: all-ones map
    fill(0); push_all(); clear_counts();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("a_first_rd_en", 64'(bus.mem_rd_en), 64'd1);
    chk("a_first_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    chk("a_busy", 64'(bus.busy), 64'd1);
    finish_run("a");

    // Run B: checkerboard, stall at (1,3), spurious start mid-run
    fill(1); push_all(); clear_counts();
    pulse_start();
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_row == 4'd1 && bus.out_col == 4'd2) found = 1;
    end
    chk("b_reach_1_2", 64'(found), 64'd1);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1;
    end
    chk("b_valid_1_3", 64'(found), 64'd1);
    snap = bus.out_pixels;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_pixels", 64'(bus.out_pixels), 64'(snap));
      chk("stall_row", 64'(bus.out_row), 64'd1);
      chk("stall_col", 64'(bus.out_col), 64'd3);
      chk("stall_no_rd", 64'(bus.mem_rd_en), 64'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    pulse_start();
    finish_run("b");

    // Run C: random map, reset during LOAD at the third read, then a clean run
    fill(2); push_all(); clear_counts();
    pulse_start();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en && bus.mem_rd_addr == 4'd2) found = 1;
    end
    chk("c_third_read", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("c_rst_busy", 64'(bus.busy), 64'd0);
    chk("c_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("c_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    push_all(); clear_counts();
    pulse_start();
    finish_run("c");

    // Run D: 6x6 instance, single output
    for (int r = 0; r < SW; r++)
      for (int c = 0; c < SW; c++)
        smap[r][c] = 1'($urandom_range(0, 3) != 0);
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        sw[i*WIN+j] = smap[i][j];
    @(posedge clk); #1 sbus.start = 1'b1;
    @(posedge clk); #1 t0 = cyc; sbus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (sbus.out_valid) found = 1;
    end
    chk("d_valid_seen", 64'(found), 64'd1);
    chk("d_latency", 64'(cyc + 1 - t0), 64'(WIN + 1 + 2 + 1));
    chk("d_row", 64'(sbus.out_row), 64'd0);
    chk("d_col", 64'(sbus.out_col), 64'd0);
    chk("d_win", 64'(sbus.win_image), 64'(sw));
    chk("d_pixels", 64'(sbus.out_pixels), ($countones(sw) >= 19) ? {46'd0, {N_OUT{1'b1}}} : 64'd0);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (sbus.done) found = 1;
    end
    chk("d_done_seen", 64'(found), 64'd1);
    @(negedge clk);
    chk("d_done_single", 64'(sbus.done), 64'd0);
    chk("d_busy_end", 64'(sbus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_pool_sched.md
# conv_pool_sched

Sequencer that drives the binary `conv_pool_channels` datapath across a full input feature map. It fetches map rows from a row-wide binary memory into a 6-row line buffer and slides a 6x6 window with stride 2. For each window position it presents the window to the datapath, waits for it to settle, and hands the N_OUT thresholded pixels downstream on a valid/ready port. It sits between the feature-map memory and the next layer's input buffer; kernels and offsets stay static datapath inputs and are not touched here.

## Interface
- IMG_W, 14, input map width in pixels; `(IMG_W-WIN)%STRIDE==0` is checked at elaboration.
- IMG_H, 14, input map height; the same divisibility rule applies.
- WIN, 6, window edge; fixed by the datapath.
- STRIDE, 2, window step in both dimensions.
- N_OUT, 18, output channels of the datapath.
- DP_LAT, 1, settle cycles allowed between window change and pixel capture; must be ≥1.
- ADDR_W, $clog2(IMG_H), memory row address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to process the whole map.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last output handshake.
- mem_rd_en  out  1  row read strobe.
- mem_rd_addr  out  ADDR_W  row index.
- mem_rd_data  in  IMG_W  row data, valid the cycle after mem_rd_en; bit j = column j.
- win_image  out  WIN*WIN  window to datapath; bit i*WIN+j = map[r0+i][c0+j].
- dp_pixel  in  N_OUT  datapath result for the current win_image.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accepts.
- out_pixels  out  N_OUT  captured dp_pixel.
- out_row, out_col  out  ADDR_W  output-map coordinate of out_pixels.

## Operation
- OUT_H = (IMG_H-WIN)/STRIDE+1 and OUT_W = (IMG_W-WIN)/STRIDE+1; the defaults give 5x5.
- IDLE: all outputs are 0. start moves to LOAD and clears the row/column counters. start while busy is ignored.
- LOAD: issues reads for rows base..base+WIN-1 on consecutive cycles, where base=0 on entry from IDLE. Each returned row is shifted into the line buffer (oldest row drops out). When the last row lands, go to WINDOW with c0=0.
- WINDOW: registers the slice of the line buffer at column c0 into win_image, then goes to WAIT.
- WAIT: counts DP_LAT cycles. On the last one it captures dp_pixel into out_pixels, latches out_row/out_col, sets out_valid and goes to EMIT.
- EMIT: holds every output stable until out_valid&&out_ready. On that handshake:
  - If not the last column: c0 += STRIDE, go to WINDOW.
  - If the last column but not the last row: go to ADVANCE.
  - Otherwise go to DONE.
- ADVANCE: issues STRIDE reads for the next rows (addresses r0+WIN .. r0+WIN+STRIDE-1), shifts them in, sets r0 += STRIDE and c0 = 0, then goes to WINDOW.
- DONE: pulses done for one cycle, deasserts busy and returns to IDLE. win_image keeps its last value.
- mem_rd_addr never exceeds IMG_H-1.
- Reset at any point returns to IDLE within the same clock-independent assertion. out_valid, busy, done and mem_rd_en go low, the counters clear and the line buffer clears. Any output in flight is lost.

## Timing
- The first read is issued in the cycle after start is sampled. The WIN reads go out on consecutive cycles; the last row is written into the buffer WIN+1 cycles after start.
- Each window costs WINDOW (1) + WAIT (DP_LAT) + EMIT (≥1) cycles: minimum 2+DP_LAT cycles per output at full out_ready.
- A row advance costs STRIDE+1 cycles.
- out_valid never drops without a handshake, and out_pixels never changes while out_valid is high.
- Outputs are produced in row-major order: (0,0), (0,1) … (OUT_H-1, OUT_W-1).

## Structure
- Package `conv_pool_pkg` holds:
  - the WIN and N_OUT constants,
  - the state enum {IDLE, LOAD, WINDOW, WAIT, EMIT, ADVANCE, DONE},
  - a `win_t` typedef for the WIN*WIN window vector.
- Sub-module `conv_line_buffer` contains the WIN×IMG_W shift register, with a shift-in port and a combinational column-slice output at c0. The FSM and counters stay in the top.

## Test plan
- All-ones 14x14 map, datapath model returning the popcount(window)≥19 bit → 25 outputs, all pixels 1; coordinates run (0,0)…(4,4) in order; done pulses exactly once.
- Map bit = (r^c)&1, out_ready held high → every win_image matches the reference slice at (2*row, 2*col); 2+DP_LAT cycles between consecutive handshakes inside a row.
- out_ready low for 10 cycles in EMIT at output (1,3) → out_valid, out_pixels and coordinates stay frozen; no reads are issued; the sequence resumes correctly.
- start pulsed again mid-run → ignored; still exactly 25 outputs and one done.
- rst_n dropped during LOAD at the third read → busy, out_valid and mem_rd_en go to 0 immediately; a later start gives a clean full run.
- Instance with IMG_W=IMG_H=6 → a single output (0,0) after WIN+1+2+DP_LAT cycles, then done.
